// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
// Decode/execute specifiers and the memory freeze flow in; forward selects and stalls flow out.
interface hazard_ctrl_if #(
    parameter int unsigned REG_W = 5
);
    logic             mem_stall;
    logic [REG_W-1:0] RsD;
    logic [REG_W-1:0] RtD;
    logic             UseRtD;
    logic [REG_W-1:0] RsE;
    logic [REG_W-1:0] RtE;
    logic [REG_W-1:0] WriteRegE;
    logic             RegWriteE;
    logic             MemtoRegE;
    logic             sel_1;
    logic             sel_2;
    logic             StallF;
    logic             StallD;
    logic             FlushE;
    logic             busy;

    modport master (
        output mem_stall, RsD, RtD, UseRtD, RsE, RtE, WriteRegE, RegWriteE, MemtoRegE,
        input  sel_1, sel_2, StallF, StallD, FlushE, busy
    );

    modport slave (
        input  mem_stall, RsD, RtD, UseRtD, RsE, RtE, WriteRegE, RegWriteE, MemtoRegE,
        output sel_1, sel_2, StallF, StallD, FlushE, busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Execute-stage hazard controller: MEM->EX ALU forwarding selects plus a load-use stall
// sequencer whose length depends on register-file write/read ordering.
module hazard_ctrl #(
    parameter int unsigned REG_W       = 5,
    parameter bit          WRITE_FIRST = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_if.slave hz
);
    // Counter load value is stall length minus the Mealy cycle spent in IDLE.
    localparam logic [1:0] LsM1 = WRITE_FIRST ? 2'd1 : 2'd2;

    typedef enum logic {StIdle, StWait} state_e;

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [REG_W-1:0] write_reg_m_q;
    logic             reg_write_m_q;
    logic             mem_to_reg_m_q;
    logic             hzd;
    logic             fwd_ok;
    logic             stall;
    logic             flush;

    // Gated by reset so outputs stay quiet while the pipeline is being reset.
    assign hzd = rst_n & hz.RegWriteE & hz.MemtoRegE & (hz.WriteRegE != '0) &
                 ((hz.WriteRegE == hz.RsD) | (hz.UseRtD & (hz.WriteRegE == hz.RtD)));

    assign fwd_ok   = reg_write_m_q & ~mem_to_reg_m_q & (write_reg_m_q != '0);
    assign hz.sel_1 = fwd_ok & (write_reg_m_q == hz.RsE);
    assign hz.sel_2 = fwd_ok & (write_reg_m_q == hz.RtE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hzd) begin
                    stall   = 1'b1;
                    flush   = 1'b1;
                    state_d = StWait;
                    cnt_d   = LsM1;
                end
            end
            StWait: begin
                stall = 1'b1;
                flush = 1'b1;
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = StIdle;
                end
            end
        endcase
        // A memory freeze holds everything in place instead of inserting bubbles.
        if (hz.mem_stall) begin
            stall   = 1'b1;
            flush   = 1'b0;
            state_d = state_q;
            cnt_d   = cnt_q;
        end
    end

    assign hz.StallF = stall;
    assign hz.StallD = stall;
    assign hz.FlushE = flush;
    assign hz.busy   = (state_q == StWait);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= 2'd0;
            write_reg_m_q  <= '0;
            reg_write_m_q  <= 1'b0;
            mem_to_reg_m_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!hz.mem_stall) begin
                write_reg_m_q  <= hz.WriteRegE;
                reg_write_m_q  <= hz.RegWriteE;
                mem_to_reg_m_q <= hz.MemtoRegE;
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (write-first and write-second register file) share
// directed and random stimulus and are compared against a stall-budget reference model.
module tb_hazard_ctrl;
    localparam int unsigned REG_W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    hazard_ctrl_if #(.REG_W(REG_W)) bus0 ();
    hazard_ctrl_if #(.REG_W(REG_W)) bus1 ();

    hazard_ctrl #(.REG_W(REG_W), .WRITE_FIRST(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .hz(bus0));
    hazard_ctrl #(.REG_W(REG_W), .WRITE_FIRST(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .hz(bus1));

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Stimulus shared by both instances.
    logic             ms, use_rt, rw_e, mtr_e;
    logic [REG_W-1:0] rs_d, rt_d, rs_e, rt_e, wr_e;

    // Reference model: M-stage record plus remaining WAIT cycles of the current stall.
    logic [REG_W-1:0] m_wr[2];
    logic             m_rw[2];
    logic             m_mtr[2];
    int               left[2];
    int               ls[2] = '{2, 3};

    // Outputs sampled at the last negedge.
    logic o_sel1[2], o_sel2[2], o_stallf[2], o_stalld[2], o_flush[2], o_busy[2];
    int   nstall[2];

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic load_use();
        return rst_n && rw_e && mtr_e && (wr_e != 0) &&
               ((wr_e == rs_d) || (use_rt && (wr_e == rt_d)));
    endfunction

    task automatic drive();
        bus0.mem_stall = ms;   bus1.mem_stall = ms;
        bus0.RsD       = rs_d; bus1.RsD       = rs_d;
        bus0.RtD       = rt_d; bus1.RtD       = rt_d;
        bus0.UseRtD    = use_rt; bus1.UseRtD  = use_rt;
        bus0.RsE       = rs_e; bus1.RsE       = rs_e;
        bus0.RtE       = rt_e; bus1.RtE       = rt_e;
        bus0.WriteRegE = wr_e; bus1.WriteRegE = wr_e;
        bus0.RegWriteE = rw_e; bus1.RegWriteE = rw_e;
        bus0.MemtoRegE = mtr_e; bus1.MemtoRegE = mtr_e;
    endtask

    // One clock: apply stimulus, compare every output at negedge, advance model after posedge.
    task automatic cycle();
        logic fwd_ok, waiting, lu, e_stall;
        drive();
        @(negedge clk);
        o_sel1[0] = bus0.sel_1;   o_sel1[1] = bus1.sel_1;
        o_sel2[0] = bus0.sel_2;   o_sel2[1] = bus1.sel_2;
        o_stallf[0] = bus0.StallF; o_stallf[1] = bus1.StallF;
        o_stalld[0] = bus0.StallD; o_stalld[1] = bus1.StallD;
        o_flush[0] = bus0.FlushE; o_flush[1] = bus1.FlushE;
        o_busy[0] = bus0.busy;    o_busy[1] = bus1.busy;
        lu = load_use();
        for (int k = 0; k < 2; k++) begin
            fwd_ok  = m_rw[k] && !m_mtr[k] && (m_wr[k] != 0);
            waiting = (left[k] > 0);
            e_stall = ms || waiting || lu;
            check($sformatf("d%0d sel_1 c%0d", k, cyc), o_sel1[k], fwd_ok && (m_wr[k] == rs_e));
            check($sformatf("d%0d sel_2 c%0d", k, cyc), o_sel2[k], fwd_ok && (m_wr[k] == rt_e));
            check($sformatf("d%0d StallF c%0d", k, cyc), o_stallf[k], e_stall);
            check($sformatf("d%0d StallD c%0d", k, cyc), o_stalld[k], e_stall);
            check($sformatf("d%0d FlushE c%0d", k, cyc), o_flush[k], !ms && (waiting || lu));
            check($sformatf("d%0d busy c%0d", k, cyc), o_busy[k], waiting);
            nstall[k] += int'(o_stallf[k]);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_wr[k] = '0; m_rw[k] = 1'b0; m_mtr[k] = 1'b0; left[k] = 0;
            end else if (!ms) begin
                if (left[k] > 0) left[k]--;
                else if (lu) left[k] = ls[k] - 1;
                m_wr[k] = wr_e; m_rw[k] = rw_e; m_mtr[k] = mtr_e;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic nop();
        ms = 1'b0; rw_e = 1'b0; mtr_e = 1'b0; wr_e = '0; use_rt = 1'b0;
        rs_d = REG_W'($urandom_range(1, 31)); rt_d = REG_W'($urandom_range(1, 31));
        rs_e = REG_W'($urandom_range(1, 31)); rt_e = REG_W'($urandom_range(1, 31));
    endtask

    task automatic load_to(input logic [REG_W-1:0] rd);
        nop(); rw_e = 1'b1; mtr_e = 1'b1; wr_e = rd;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_wr[k] = '0; m_rw[k] = 1'b0; m_mtr[k] = 1'b0; left[k] = 0; nstall[k] = 0;
        end
        rst_n = 1'b0;
        nop();
        drive();
        @(posedge clk);
        #1;

        // Reset with arbitrary inputs, including a would-be load-use.
        load_to(5'd4); rs_d = 5'd4; rs_e = 5'd0; rt_e = 5'd0;
        cycle();
        rw_e = 1'b1; mtr_e = 1'b0; wr_e = 5'd9;
        cycle();
        check("rst stallf", o_stallf[0] | o_stallf[1], 1'b0);
        rst_n = 1'b1;
        nop(); cycle();

        // ALU->ALU forward, then register 0 never forwarded.
        nop(); rw_e = 1'b1; wr_e = 5'd5; cycle();
        nop(); rs_e = 5'd5; rt_e = 5'd5; cycle();
        check("fwd sel_1", o_sel1[0], 1'b1);
        check("fwd sel_2", o_sel2[1], 1'b1);
        nop(); rw_e = 1'b1; wr_e = 5'd0; cycle();
        nop(); rs_e = 5'd0; rt_e = 5'd0; cycle();
        check("fwd r0", o_sel1[0] | o_sel2[0], 1'b0);

        // Load-use on Rs: dependent sits in D, E then carries bubbles.
        nstall = '{0, 0};
        load_to(5'd3); rs_d = 5'd3; cycle();
        for (int i = 0; i < 5; i++) begin
            nop(); rs_d = 5'd3; rs_e = 5'd3; cycle();
            if (i == 0) check("load no fwd", o_sel1[0], 1'b0);
        end
        check_int("ls rs wf1", nstall[0], 2);
        check_int("ls rs wf0", nstall[1], 3);

        // Load-use on Rt, then same values with UseRtD=0.
        nstall = '{0, 0};
        load_to(5'd7); rs_d = 5'd1; rt_d = 5'd7; use_rt = 1'b1; cycle();
        for (int i = 0; i < 5; i++) begin nop(); cycle(); end
        check_int("ls rt wf1", nstall[0], 2);
        check_int("ls rt wf0", nstall[1], 3);
        nstall = '{0, 0};
        load_to(5'd7); rs_d = 5'd1; rt_d = 5'd7; use_rt = 1'b0; cycle();
        for (int i = 0; i < 3; i++) begin nop(); cycle(); end
        check_int("no use rt", nstall[0] + nstall[1], 0);

        // Memory freeze of two cycles inside WAIT stretches the stall by two.
        nstall = '{0, 0};
        load_to(5'd2); rs_d = 5'd2; cycle();
        nop(); ms = 1'b1; cycle();
        check("freeze flush", o_flush[0] | o_flush[1], 1'b0);
        check("freeze busy", o_busy[0] & o_busy[1], 1'b1);
        nop(); ms = 1'b1; cycle();
        for (int i = 0; i < 6; i++) begin nop(); cycle(); end
        check_int("freeze wf1", nstall[0], 4);
        check_int("freeze wf0", nstall[1], 5);

        // Reset during WAIT.
        load_to(5'd6); rs_d = 5'd6; cycle();
        nop(); rst_n = 1'b0; cycle();
        rst_n = 1'b1; nop(); cycle();
        check("rstwait stall", o_stallf[0] | o_stallf[1] | o_flush[0] | o_flush[1], 1'b0);
        check("rstwait busy", o_busy[0] | o_busy[1], 1'b0);

        // Random traffic on a small register set to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            ms     = ($urandom_range(0, 5) == 0);
            rst_n  = ($urandom_range(0, 49) != 0);
            use_rt = 1'($urandom);
            rw_e   = 1'($urandom);
            mtr_e  = 1'($urandom);
            rs_d   = REG_W'($urandom_range(0, 3));
            rt_d   = REG_W'($urandom_range(0, 3));
            rs_e   = REG_W'($urandom_range(0, 3));
            rt_e   = REG_W'($urandom_range(0, 3));
            wr_e   = REG_W'($urandom_range(0, 3));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
